lsu_amo_seq: RTL and testbench
==============================

# lsu_amo_seq

LSU-side sequencer for RISC-V A-extension atomics: the initiator end of the `lsu2amo`/`amo2lsu` interface. It accepts one atomic request at a time from the execute stage and performs the memory read over the data bus. It hands the read word to the `amo` unit, collects the computed store word, performs the memory write, and returns the `rd` value to writeback. It sits inside the LSU between the execute-stage request port and the shared data-bus master.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: data-bus wait limit; only used when the timeout feature is compiled in.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid_i` in 1: execute stage presents an atomic.
- `req_ready_o` out 1: sequencer can accept a request.
- `req_ops_i` in `type_amo_ops_e`: LR, SC, SWAP, ADD, AND, OR, XOR, MIN, MAX, MINU, MAXU.
- `req_addr_i` in 32: effective address.
- `req_rs2_i` in 32: rs2 operand.
- `req_rd_i` in 5: destination register.
- `dbus_req_o` out 1: data-bus request.
- `dbus_we_o` out 1: data-bus write enable.
- `dbus_addr_o` out 32: data-bus address.
- `dbus_wdata_o` out 32: data-bus write data.
- `dbus_sel_o` out 4: byte enables.
- `dbus_ack_i` in 1: data-bus acknowledge.
- `dbus_rdata_i` in 32: data-bus read data.
- `lsu2amo_data_o` out `type_lsu2amo_data_s`: `r_data`, `rs2_operand`, `lsu_addr`.
- `lsu2amo_ctrl_o` out `type_lsu2amo_ctrl_s`: `is_amo`, `amo_ops`, `ack`.
- `amo2lsu_data_i` in `type_amo2lsu_data_s`: `w_data` (store word), `rd_data` (writeback value).
- `amo2lsu_ctrl_i` in `type_amo2lsu_ctrl_s`: `done`, `wr_req`.
- `wb_valid_o` out 1: writeback pulse.
- `wb_rd_o` out 5: writeback register.
- `wb_data_o` out 32: writeback data.
- `excp_misaligned_o` out 1: misaligned-address exception pulse.
- `bus_err_o` out 1: bus timeout pulse; tied to 0 when the timeout feature is compiled out.

## Operation
- States: IDLE, RD, CALC, WR, RESP.
- IDLE
  - `req_ready_o`=1.
  - On `req_valid_i`, latch ops, addr, rs2 and rd.
  - If `addr[1:0]`≠0: pulse `excp_misaligned_o` for 1 cycle, make no bus access, stay in IDLE.
  - Else if ops=SC: go to CALC with `r_data`=0.
  - Else: go to RD.
- RD
  - Drive `dbus_req_o`=1, `dbus_we_o`=0, `dbus_sel_o`=4'hF.
  - On `dbus_ack_i`: capture `dbus_rdata_i` and go to CALC.
- CALC
  - `is_amo`=1, `amo_ops` and data fields held stable.
  - `ack`=1 only on the first CALC cycle (1-cycle pulse).
  - Wait for `amo2lsu_ctrl_i.done`. When it is seen, latch `w_data` and `rd_data`.
  - Then go to WR if `wr_req`=1, else to RESP.
  - LR always has `wr_req`=0. A failed SC has `wr_req`=0 with `rd_data`=1.
- WR
  - Drive `dbus_req_o`=1, `dbus_we_o`=1, `dbus_wdata_o`=latched `w_data`.
  - On `dbus_ack_i`: go to RESP.
- RESP
  - `wb_valid_o`=1 for 1 cycle with latched `rd` and `rd_data`, then go to IDLE.
- `dbus_addr_o` is always the latched address. Outside RD/WR, `dbus_req_o`=0.
- Only one outstanding request. `req_valid_i` outside IDLE is ignored; it is not lost, because ready is 0.

## Timing
- Reset (`rst_n`=0 at a rising edge): state=IDLE; every output 0 except `req_ready_o`=1.
- Reset mid-operation aborts the sequence. `dbus_req_o` drops at that edge. No writeback and no partial write are issued.
- Minimum latency with zero-wait bus and a `done` on the first CALC cycle: request accept → `wb_valid_o` is 4 cycles for an AMO with write, 3 cycles for LR.
- `dbus_ack_i` is sampled only in RD/WR. A stray ack in any other state is ignored.
- `done` and `ack` arriving in the same cycle as the CALC entry edge are both honoured.

## Configuration
- `AMO_SEQ_BUS_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to RD/WR and increments each waiting cycle.
  - When it reaches `TIMEOUT_CYCLES` with no ack: pulse `bus_err_o`, drop `dbus_req_o`, go to IDLE, no writeback.
- Not defined: no counter; `bus_err_o` is constant 0; RD/WR wait indefinitely.

## Structure
- The structs and `type_amo_ops_e` (`AMO_OPS_*`) live in the shared package `a_ext_defs.svh`.
- Add `type_amo_seq_state_e` to the same package.
- Single FSM module; the timeout counter is inline. No sub-module.

## Test plan
- AMOADD: addr 0x1000, rs2 0x8, memory returns 0x10, `amo` returns `w_data`=0x18 and `rd_data`=0x10 → bus write 0x18 to 0x1000; `wb_data_o`=0x10 with the requested rd.
- LR then SC:
  - LR reads 0x10 → `wb_data_o`=0x10, no write.
  - SC with `wr_req`=1 → no read; write of rs2 0xA5A5A5A5; `wb_data_o`=0.
- Failed SC: `amo` returns `wr_req`=0, `rd_data`=1 → no bus activity; `wb_data_o`=1.
- Misaligned: addr 0x1002 → `excp_misaligned_o` pulse, `dbus_req_o` stays 0, no `wb_valid_o`.
- Wait states and reset:
  - 3-cycle ack delay in both RD and WR → latency is 6 cycles longer than the zero-wait case.
  - `rst_n` low during WR → `dbus_req_o`=0 at the next edge; state is IDLE.
- With `AMO_SEQ_BUS_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4: ack withheld in RD → `bus_err_o` pulse after 4 wait cycles, return to IDLE.

Source files
------------

// File: rtl/lsu_amo_seq_pkg.sv
// Shared A-extension definitions: atomic op encoding, lsu<->amo handshake structs,
// and the LSU atomic sequencer state encoding.
package lsu_amo_seq_pkg;

  typedef enum logic [3:0] {
    AMO_OPS_LR   = 4'd0,
    AMO_OPS_SC   = 4'd1,
    AMO_OPS_SWAP = 4'd2,
    AMO_OPS_ADD  = 4'd3,
    AMO_OPS_AND  = 4'd4,
    AMO_OPS_OR   = 4'd5,
    AMO_OPS_XOR  = 4'd6,
    AMO_OPS_MIN  = 4'd7,
    AMO_OPS_MAX  = 4'd8,
    AMO_OPS_MINU = 4'd9,
    AMO_OPS_MAXU = 4'd10
  } type_amo_ops_e;

  typedef enum logic [2:0] {
    AMO_SEQ_IDLE = 3'd0,
    AMO_SEQ_RD   = 3'd1,
    AMO_SEQ_CALC = 3'd2,
    AMO_SEQ_WR   = 3'd3,
    AMO_SEQ_RESP = 3'd4
  } type_amo_seq_state_e;

  typedef struct packed {
    logic [31:0] r_data;
    logic [31:0] rs2_operand;
    logic [31:0] lsu_addr;
  } type_lsu2amo_data_s;

  typedef struct packed {
    logic          is_amo;
    type_amo_ops_e amo_ops;
    logic          ack;
  } type_lsu2amo_ctrl_s;

  typedef struct packed {
    logic [31:0] w_data;
    logic [31:0] rd_data;
  } type_amo2lsu_data_s;

  typedef struct packed {
    logic done;
    logic wr_req;
  } type_amo2lsu_ctrl_s;

  // Atomics always move a full aligned word.
  localparam logic [3:0] DBUS_SEL_WORD = 4'hF;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/lsu_amo_seq.sv
// LSU-side sequencer for RISC-V atomics: read, hand to amo unit, write back, respond.
// Optional data-bus timeout is compiled in with `define AMO_SEQ_BUS_TIMEOUT_EN.
module lsu_amo_seq
  import lsu_amo_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  type_amo_ops_e      req_ops_i,
  input  logic [31:0]        req_addr_i,
  input  logic [31:0]        req_rs2_i,
  input  logic [4:0]         req_rd_i,
  output logic               dbus_req_o,
  output logic               dbus_we_o,
  output logic [31:0]        dbus_addr_o,
  output logic [31:0]        dbus_wdata_o,
  output logic [3:0]         dbus_sel_o,
  input  logic               dbus_ack_i,
  input  logic [31:0]        dbus_rdata_i,
  output type_lsu2amo_data_s lsu2amo_data_o,
  output type_lsu2amo_ctrl_s lsu2amo_ctrl_o,
  input  type_amo2lsu_data_s amo2lsu_data_i,
  input  type_amo2lsu_ctrl_s amo2lsu_ctrl_i,
  output logic               wb_valid_o,
  output logic [4:0]         wb_rd_o,
  output logic [31:0]        wb_data_o,
  output logic               excp_misaligned_o,
  output logic               bus_err_o
);

  type_amo_seq_state_e state_reg, state_next;
  type_amo_ops_e       ops_reg;
  logic [31:0]         addr_reg;
  logic [31:0]         rs2_reg;
  logic [31:0]         r_data_reg;
  logic [31:0]         w_data_reg;
  logic [31:0]         rd_data_reg;
  logic [4:0]          rd_reg;
  logic                ack_reg;
  logic                excp_reg;
  logic                bus_err_reg;

  logic accept;
  logic misaligned;
  logic bus_active;
  logic bus_timeout;
  logic calc_done;

  assign accept     = (state_reg == AMO_SEQ_IDLE) && req_valid_i;
  assign misaligned = !is_word_aligned(req_addr_i[1:0]);
  assign bus_active = (state_reg == AMO_SEQ_RD) || (state_reg == AMO_SEQ_WR);
  assign calc_done  = (state_reg == AMO_SEQ_CALC) && amo2lsu_ctrl_i.done;

`ifdef AMO_SEQ_BUS_TIMEOUT_EN
  logic [7:0] tmo_cnt_reg;
  logic       bus_entry;

  // Counter restarts whenever the FSM moves into a bus phase.
  assign bus_entry   = (state_next != state_reg) &&
                       ((state_next == AMO_SEQ_RD) || (state_next == AMO_SEQ_WR));
  assign bus_timeout = bus_active && !dbus_ack_i &&
                       ((tmo_cnt_reg + 8'd1) == 8'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_reg <= 8'd0;
    end else if (bus_entry) begin
      tmo_cnt_reg <= 8'd0;
    end else if (bus_active && !dbus_ack_i) begin
      tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
    end
  end

  assign bus_err_o = bus_err_reg;
`else
  logic unused_timeout_cfg;

  assign bus_timeout        = 1'b0;
  assign unused_timeout_cfg = ^8'(TIMEOUT_CYCLES);
  assign bus_err_o          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= AMO_SEQ_IDLE;
      ops_reg     <= AMO_OPS_LR;
      addr_reg    <= 32'd0;
      rs2_reg     <= 32'd0;
      r_data_reg  <= 32'd0;
      w_data_reg  <= 32'd0;
      rd_data_reg <= 32'd0;
      rd_reg      <= 5'd0;
      ack_reg     <= 1'b0;
      excp_reg    <= 1'b0;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      excp_reg    <= accept && misaligned;
      bus_err_reg <= bus_timeout;
      // ack marks only the first CALC cycle.
      ack_reg     <= (state_next == AMO_SEQ_CALC) && (state_reg != AMO_SEQ_CALC);
      if (accept) begin
        ops_reg    <= req_ops_i;
        addr_reg   <= req_addr_i;
        rs2_reg    <= req_rs2_i;
        rd_reg     <= req_rd_i;
        r_data_reg <= 32'd0;
      end
      if ((state_reg == AMO_SEQ_RD) && dbus_ack_i) begin
        r_data_reg <= dbus_rdata_i;
      end
      if (calc_done) begin
        w_data_reg  <= amo2lsu_data_i.w_data;
        rd_data_reg <= amo2lsu_data_i.rd_data;
      end
    end
  end

  always_comb begin
    state_next             = state_reg;
    req_ready_o            = 1'b0;
    dbus_req_o             = 1'b0;
    dbus_we_o              = 1'b0;
    wb_valid_o             = 1'b0;
    lsu2amo_ctrl_o.is_amo  = 1'b0;
    lsu2amo_ctrl_o.amo_ops = ops_reg;
    lsu2amo_ctrl_o.ack     = 1'b0;

    case (state_reg)
      AMO_SEQ_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i && !misaligned) begin
          // SC needs no read; reservation check is the amo unit's job.
          state_next = (req_ops_i == AMO_OPS_SC) ? AMO_SEQ_CALC : AMO_SEQ_RD;
        end
      end
      AMO_SEQ_RD: begin
        dbus_req_o = 1'b1;
        if (dbus_ack_i) begin
          state_next = AMO_SEQ_CALC;
        end else if (bus_timeout) begin
          state_next = AMO_SEQ_IDLE;
        end
      end
      AMO_SEQ_CALC: begin
        lsu2amo_ctrl_o.is_amo = 1'b1;
        lsu2amo_ctrl_o.ack    = ack_reg;
        if (amo2lsu_ctrl_i.done) begin
          state_next = amo2lsu_ctrl_i.wr_req ? AMO_SEQ_WR : AMO_SEQ_RESP;
        end
      end
      AMO_SEQ_WR: begin
        dbus_req_o = 1'b1;
        dbus_we_o  = 1'b1;
        if (dbus_ack_i) begin
          state_next = AMO_SEQ_RESP;
        end else if (bus_timeout) begin
          state_next = AMO_SEQ_IDLE;
        end
      end
      AMO_SEQ_RESP: begin
        wb_valid_o = 1'b1;
        state_next = AMO_SEQ_IDLE;
      end
      default: begin
        state_next = AMO_SEQ_IDLE;
      end
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_sel
    assign dbus_sel_o[gi] = bus_active & DBUS_SEL_WORD[gi];
  end

  assign dbus_addr_o                = addr_reg;
  assign dbus_wdata_o               = w_data_reg;
  assign lsu2amo_data_o.r_data      = r_data_reg;
  assign lsu2amo_data_o.rs2_operand = rs2_reg;
  assign lsu2amo_data_o.lsu_addr    = addr_reg;
  assign wb_rd_o                    = rd_reg;
  assign wb_data_o                  = rd_data_reg;
  assign excp_misaligned_o          = excp_reg;

endmodule

// File: tb/tb_lsu_amo_seq.sv
// Directed bench for lsu_amo_seq: bus and amo responders are modelled inline per transaction.
module tb_lsu_amo_seq;
  import lsu_amo_seq_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req_valid_i;
  logic               req_ready_o;
  type_amo_ops_e      req_ops_i;
  logic [31:0]        req_addr_i;
  logic [31:0]        req_rs2_i;
  logic [4:0]         req_rd_i;
  logic               dbus_req_o;
  logic               dbus_we_o;
  logic [31:0]        dbus_addr_o;
  logic [31:0]        dbus_wdata_o;
  logic [3:0]         dbus_sel_o;
  logic               dbus_ack_i;
  logic [31:0]        dbus_rdata_i;
  type_lsu2amo_data_s lsu2amo_data_o;
  type_lsu2amo_ctrl_s lsu2amo_ctrl_o;
  type_amo2lsu_data_s amo2lsu_data_i;
  type_amo2lsu_ctrl_s amo2lsu_ctrl_i;
  logic               wb_valid_o;
  logic [4:0]         wb_rd_o;
  logic [31:0]        wb_data_o;
  logic               excp_misaligned_o;
  logic               bus_err_o;

  always #5 clk = ~clk;

  lsu_amo_seq #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_ops_i(req_ops_i),
    .req_addr_i(req_addr_i), .req_rs2_i(req_rs2_i), .req_rd_i(req_rd_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_sel_o(dbus_sel_o), .dbus_ack_i(dbus_ack_i),
    .dbus_rdata_i(dbus_rdata_i),
    .lsu2amo_data_o(lsu2amo_data_o), .lsu2amo_ctrl_o(lsu2amo_ctrl_o),
    .amo2lsu_data_i(amo2lsu_data_i), .amo2lsu_ctrl_i(amo2lsu_ctrl_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .excp_misaligned_o(excp_misaligned_o), .bus_err_o(bus_err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Observations from the last transaction
  int          lat, n_rd_acks, n_wr_acks, n_rd_cyc, n_wr_cyc, n_wb, n_excp, n_ack_pulse;
  int          n_buserr, buserr_k;
  logic [31:0] wr_addr, wr_data, wb_data, seen_rdata, seen_rs2, seen_addr;
  logic [3:0]  rd_sel, seen_ops;
  logic [4:0]  wb_rd;
  logic        we_at_rst, post_req, post_ready;

  task automatic run_txn(input string tag, input type_amo_ops_e ops, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [4:0] rd, input logic [31:0] mem_rdata,
                         input logic [31:0] amo_w, input logic [31:0] amo_rd, input logic amo_wr,
                         input int rd_wait, input int wr_wait, input int rst_at);
    int wcnt;
    wcnt = 0;
    lat = -1; n_rd_acks = 0; n_wr_acks = 0; n_rd_cyc = 0; n_wr_cyc = 0; n_wb = 0;
    n_excp = 0; n_ack_pulse = 0; n_buserr = 0; buserr_k = -1;
    wr_addr = '0; wr_data = '0; wb_data = '0; seen_rdata = '0; seen_rs2 = '0; seen_addr = '0;
    rd_sel = '0; seen_ops = '0; wb_rd = '0; we_at_rst = 1'b0; post_req = 1'b1; post_ready = 1'b0;
    @(negedge clk);
    check_eq({tag, ".ready"}, 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_ops_i = ops; req_addr_i = addr; req_rs2_i = rs2; req_rd_i = rd;
    @(posedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      req_valid_i    = 1'b0;
      dbus_ack_i     = 1'b0;
      dbus_rdata_i   = 32'hDEADBEEF;
      amo2lsu_ctrl_i = '0;
      amo2lsu_data_i = '{w_data: 32'hBAD0BAD0, rd_data: 32'hBAD1BAD1};
      if (rst_at >= 0 && k == rst_at + 1) begin
        post_req = dbus_req_o; post_ready = req_ready_o; rst_n = 1'b1;
      end
      if (wb_valid_o) begin
        n_wb++;
        if (lat < 0) begin lat = k; wb_data = wb_data_o; wb_rd = wb_rd_o; end
      end
      if (excp_misaligned_o) n_excp++;
      if (bus_err_o) begin n_buserr++; if (buserr_k < 0) buserr_k = k; end
      if (lsu2amo_ctrl_o.ack) n_ack_pulse++;
      if (lsu2amo_ctrl_o.is_amo) begin
        seen_rdata = lsu2amo_data_o.r_data; seen_rs2 = lsu2amo_data_o.rs2_operand;
        seen_addr = lsu2amo_data_o.lsu_addr; seen_ops = lsu2amo_ctrl_o.amo_ops;
        amo2lsu_ctrl_i = '{done: 1'b1, wr_req: amo_wr};
        amo2lsu_data_i = '{w_data: amo_w, rd_data: amo_rd};
      end
      if (rst_at >= 0 && k == rst_at) begin
        we_at_rst = dbus_we_o; rst_n = 1'b0;
      end else if (dbus_req_o) begin
        if (!dbus_we_o) n_rd_cyc++; else n_wr_cyc++;
        if (wcnt == (dbus_we_o ? wr_wait : rd_wait)) begin
          dbus_ack_i = 1'b1; wcnt = 0;
          if (!dbus_we_o) begin
            dbus_rdata_i = mem_rdata; n_rd_acks++; rd_sel = dbus_sel_o;
          end else begin
            n_wr_acks++; wr_addr = dbus_addr_o; wr_data = dbus_wdata_o;
          end
        end else begin
          wcnt++;
        end
      end
    end
    $display("txn %-8s addr=0x%08h lat=%0d rd=%0d wr=%0d wb=%0d wb_data=0x%08h excp=%0d",
             tag, addr, lat, n_rd_acks, n_wr_acks, n_wb, wb_data, n_excp);
  endtask

  initial begin
    req_valid_i = 1'b0; req_ops_i = AMO_OPS_LR; req_addr_i = '0; req_rs2_i = '0; req_rd_i = '0;
    dbus_ack_i = 1'b0; dbus_rdata_i = '0; amo2lsu_data_i = '0; amo2lsu_ctrl_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst.ready", 32'(req_ready_o), 32'd1);
    check_eq("rst.dbus_req", 32'(dbus_req_o), 32'd0);
    check_eq("rst.sel", 32'(dbus_sel_o), 32'd0);
    check_eq("rst.addr", dbus_addr_o, 32'd0);
    check_eq("rst.wb_valid", 32'(wb_valid_o), 32'd0);
    check_eq("rst.is_amo", 32'(lsu2amo_ctrl_o.is_amo), 32'd0);
    check_eq("rst.excp", 32'(excp_misaligned_o), 32'd0);
    check_eq("rst.bus_err", 32'(bus_err_o), 32'd0);
    rst_n = 1'b1;

    // AMOADD, zero-wait bus
    run_txn("amoadd", AMO_OPS_ADD, 32'h1000, 32'h8, 5'd5, 32'h10, 32'h18, 32'h10, 1'b1, 0, 0, -1);
    check_eq("add.lat", 32'(lat), 32'd4);
    check_eq("add.rd_acks", 32'(n_rd_acks), 32'd1);
    check_eq("add.rd_sel", 32'(rd_sel), 32'hF);
    check_eq("add.amo_rdata", seen_rdata, 32'h10);
    check_eq("add.amo_rs2", seen_rs2, 32'h8);
    check_eq("add.amo_addr", seen_addr, 32'h1000);
    check_eq("add.amo_ops", 32'(seen_ops), 32'(AMO_OPS_ADD));
    check_eq("add.ack_pulses", 32'(n_ack_pulse), 32'd1);
    check_eq("add.wr_acks", 32'(n_wr_acks), 32'd1);
    check_eq("add.wr_addr", wr_addr, 32'h1000);
    check_eq("add.wr_data", wr_data, 32'h18);
    check_eq("add.wb_n", 32'(n_wb), 32'd1);
    check_eq("add.wb_data", wb_data, 32'h10);
    check_eq("add.wb_rd", 32'(wb_rd), 32'd5);
    check_eq("add.bus_err", 32'(n_buserr), 32'd0);

    // LR: read only
    run_txn("lr", AMO_OPS_LR, 32'h1000, 32'h0, 5'd7, 32'h10, 32'h0, 32'h10, 1'b0, 0, 0, -1);
    check_eq("lr.lat", 32'(lat), 32'd3);
    check_eq("lr.rd_acks", 32'(n_rd_acks), 32'd1);
    check_eq("lr.wr_cyc", 32'(n_wr_cyc), 32'd0);
    check_eq("lr.wb_data", wb_data, 32'h10);
    check_eq("lr.wb_rd", 32'(wb_rd), 32'd7);

    // SC success: no read, write rs2
    run_txn("sc", AMO_OPS_SC, 32'h1000, 32'hA5A5A5A5, 5'd9, 32'h77, 32'hA5A5A5A5, 32'h0, 1'b1, 0, 0, -1);
    check_eq("sc.rd_cyc", 32'(n_rd_cyc), 32'd0);
    check_eq("sc.amo_rdata", seen_rdata, 32'h0);
    check_eq("sc.amo_rs2", seen_rs2, 32'hA5A5A5A5);
    check_eq("sc.wr_data", wr_data, 32'hA5A5A5A5);
    check_eq("sc.wr_addr", wr_addr, 32'h1000);
    check_eq("sc.lat", 32'(lat), 32'd3);
    check_eq("sc.wb_data", wb_data, 32'h0);

    // SC failure: no bus traffic at all
    run_txn("sc_fail", AMO_OPS_SC, 32'h1000, 32'h5A5A5A5A, 5'd10, 32'h77, 32'h0, 32'h1, 1'b0, 0, 0, -1);
    check_eq("scf.bus_cyc", 32'(n_rd_cyc + n_wr_cyc), 32'd0);
    check_eq("scf.lat", 32'(lat), 32'd2);
    check_eq("scf.wb_data", wb_data, 32'h1);

    // Misaligned: exception pulse, no bus, no writeback
    run_txn("misalign", AMO_OPS_ADD, 32'h1002, 32'h1, 5'd3, 32'h10, 32'h0, 32'h0, 1'b1, 0, 0, -1);
    check_eq("mis.excp", 32'(n_excp), 32'd1);
    check_eq("mis.bus_cyc", 32'(n_rd_cyc + n_wr_cyc), 32'd0);
    check_eq("mis.wb_n", 32'(n_wb), 32'd0);

    // Three wait states in both RD and WR
    run_txn("swap_ws", AMO_OPS_SWAP, 32'h2000, 32'h1234, 5'd11, 32'hCAFE, 32'h1234, 32'hCAFE, 1'b1, 3, 3, -1);
    check_eq("ws.lat", 32'(lat), 32'd10);
    check_eq("ws.rd_cyc", 32'(n_rd_cyc), 32'd4);
    check_eq("ws.wr_data", wr_data, 32'h1234);
    check_eq("ws.wb_data", wb_data, 32'hCAFE);
    check_eq("ws.bus_err", 32'(n_buserr), 32'd0);

    // Reset while WR is waiting for ack
    run_txn("rst_wr", AMO_OPS_ADD, 32'h3000, 32'h1, 5'd12, 32'h5, 32'h6, 32'h5, 1'b1, 0, 20, 3);
    check_eq("rw.in_wr", 32'(we_at_rst), 32'd1);
    check_eq("rw.post_req", 32'(post_req), 32'd0);
    check_eq("rw.post_ready", 32'(post_ready), 32'd1);
    check_eq("rw.wr_acks", 32'(n_wr_acks), 32'd0);
    check_eq("rw.wb_n", 32'(n_wb), 32'd0);

`ifdef AMO_SEQ_BUS_TIMEOUT_EN
    // Read ack withheld: error after 4 wait cycles
    run_txn("timeout", AMO_OPS_ADD, 32'h4000, 32'h1, 5'd13, 32'h5, 32'h6, 32'h5, 1'b1, 100, 0, -1);
    check_eq("tmo.rd_cyc", 32'(n_rd_cyc), 32'd4);
    check_eq("tmo.err_n", 32'(n_buserr), 32'd1);
    check_eq("tmo.err_at", 32'(buserr_k), 32'd5);
    check_eq("tmo.wb_n", 32'(n_wb), 32'd0);
`endif

    // Sequencer must be idle again after all of the above
    @(negedge clk);
    check_eq("end.ready", 32'(req_ready_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
